// File: rtl/i2c_apb_pkg.sv
// ----------------------------------------------------------------------------
// i2c_apb_pkg
// Shared types for the APB command master that feeds the I2C controller's
// APB slave port.
//   APB_ADDR_W / APB_DATA_W : default APB address / data widths
//   apb_state_e             : APB master phase (IDLE, SETUP, ACCESS)
//   apb_cmd_t               : one queued register command {write, addr, wdata}
// ----------------------------------------------------------------------------
package i2c_apb_pkg;

   localparam int APB_ADDR_W = 8;
   localparam int APB_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } apb_state_e;

   typedef struct packed {
      logic                  write;
      logic [APB_ADDR_W-1:0] addr;
      logic [APB_DATA_W-1:0] wdata;
   } apb_cmd_t;

endpackage

// File: rtl/apb_cmd_fifo.sv
// ----------------------------------------------------------------------------
// apb_cmd_fifo
// Synchronous command queue. Pointers carry one extra wrap bit so that
// full and empty are told apart without an occupancy counter.
// Ports:
//   pclk, preset : clock, asynchronous active-high reset (flushes the queue)
//   push, din    : write request and entry; ignored while full
//   pop          : drop head entry; ignored while empty
//   full, empty  : queue status
//   dout         : current head entry (valid while !empty)
// ----------------------------------------------------------------------------
module apb_cmd_fifo
   import i2c_apb_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = apb_cmd_t
) (
   input  logic pclk,
   input  logic preset,
   input  logic push,
   input  T     din,
   input  logic pop,
   output logic full,
   output logic empty,
   output T     dout
);

   localparam int PTR_W = $clog2(DEPTH);

   T               mem [DEPTH];
   logic [PTR_W:0] wr_ptr;
   logic [PTR_W:0] rd_ptr;
   logic           do_push;
   logic           do_pop;

   // Same index with opposite wrap bits means the writer is a full lap ahead.
   assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr[PTR_W-1:0]];

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      end
   end

   // NOTE: storage is deliberately not reset; the pointers alone decide which
   // entries are valid, so clearing the array would only cost reset fan-out.
   always_ff @(posedge pclk) begin
      if (do_push) mem[wr_ptr[PTR_W-1:0]] <= din;
   end

endmodule

// File: rtl/apb_cmd_master.sv
// ----------------------------------------------------------------------------
// apb_cmd_master
// Turns queued register commands into APB3 transfers towards the I2C block
// and returns one response per command. All APB outputs are registered.
// Ports:
//   pclk, preset        : APB clock, asynchronous active-high reset
//   cmd_valid_i/ready_o : command handshake (ready = queue not full)
//   cmd_write_i         : 1 = write, 0 = read
//   cmd_addr_i          : target register address
//   cmd_wdata_i         : write data (ignored for reads)
//   rsp_valid_o         : one-cycle completion pulse, no backpressure
//   rsp_rdata_o         : read data; 0 for writes and timeouts (held)
//   rsp_timeout_o       : transfer aborted after TIMEOUT_CYC wait cycles (held)
//   busy_o              : transfer in flight or commands queued
//   paddr/pwrite/psel/penable/pwdata : APB master outputs
//   prdata/pready       : APB slave returns
// ----------------------------------------------------------------------------
module apb_cmd_master
   import i2c_apb_pkg::*;
#(
   parameter int ADDR_W      = APB_ADDR_W,
   parameter int DATA_W      = APB_DATA_W,
   parameter int FIFO_DEPTH  = 4,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              pclk,
   input  logic              preset,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic              cmd_write_i,
   input  logic [ADDR_W-1:0] cmd_addr_i,
   input  logic [DATA_W-1:0] cmd_wdata_i,
   output logic              rsp_valid_o,
   output logic [DATA_W-1:0] rsp_rdata_o,
   output logic              rsp_timeout_o,
   output logic              busy_o,
   output logic [ADDR_W-1:0] paddr,
   output logic              pwrite,
   output logic              psel,
   output logic              penable,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready
);

   // Command layout follows this instance's widths, not the package defaults.
   typedef struct packed {
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } cmd_t;

   localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
   // Count value seen during the last permitted ACCESS wait cycle.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   apb_state_e       state;
   logic [CNT_W-1:0] tmo_cnt;
   cmd_t             push_cmd;
   cmd_t             head_cmd;
   logic             fifo_full;
   logic             fifo_empty;
   logic             pop;

   assign push_cmd    = '{write: cmd_write_i, addr: cmd_addr_i, wdata: cmd_wdata_i};
   assign pop         = (state == IDLE) && !fifo_empty;
   assign cmd_ready_o = !fifo_full;
   assign busy_o      = (state != IDLE) || !fifo_empty;

   apb_cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .T     (cmd_t)
   ) u_fifo (
      .pclk   (pclk),
      .preset (preset),
      .push   (cmd_valid_i),
      .din    (push_cmd),
      .pop    (pop),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .dout   (head_cmd)
   );

   // NOTE: every register here uses non-blocking assignment so all of them
   // update together at the edge and no branch sees a half-updated value.
   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         state         <= IDLE;
         tmo_cnt       <= '0;
         paddr         <= '0;
         pwrite        <= 1'b0;
         pwdata        <= '0;
         psel          <= 1'b0;
         penable       <= 1'b0;
         rsp_valid_o   <= 1'b0;
         rsp_rdata_o   <= '0;
         rsp_timeout_o <= 1'b0;
      end else begin
         rsp_valid_o <= 1'b0;
         unique case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  paddr   <= head_cmd.addr;
                  pwrite  <= head_cmd.write;
                  pwdata  <= head_cmd.wdata;
                  psel    <= 1'b1;
                  penable <= 1'b0;
                  tmo_cnt <= '0;
                  state   <= SETUP;
               end
            end
            SETUP: begin
               penable <= 1'b1;
               state   <= ACCESS;
            end
            ACCESS: begin
               // Stops at TIMEOUT_CYC at most, so the counter never wraps.
               tmo_cnt <= tmo_cnt + 1'b1;
               if (pready) begin
                  psel          <= 1'b0;
                  penable       <= 1'b0;
                  rsp_valid_o   <= 1'b1;
                  rsp_timeout_o <= 1'b0;
                  rsp_rdata_o   <= pwrite ? '0 : prdata;
                  state         <= IDLE;
               end else if (tmo_cnt == CNT_LAST) begin
                  psel          <= 1'b0;
                  penable       <= 1'b0;
                  rsp_valid_o   <= 1'b1;
                  rsp_timeout_o <= 1'b1;
                  rsp_rdata_o   <= '0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
